led_zone_rd_ctrl: RTL
=====================

# led_zone_rd_ctrl

Read-side sequencer for the `fifo_led` zone-brightness FIFO in the local-dimming path. On each `frame_start` it pulls exactly `ZONE_NUM` brightness bytes from the FIFO. It stalls while the FIFO is empty and buffers the one-cycle read latency in a 2-entry skid buffer. Each byte is presented to the LED driver interface as an indexed valid/ready stream, and the block reports frame completion and overrun.

## Interface
Parameters:
- `DATA_WIDTH`, 8: zone brightness width; equals FIFO read data width.
- `ZONE_NUM`, 64: zones per frame; legal range 1..1024.
- `IDX_WIDTH`, 10: width of zone index and counters; must satisfy 2**IDX_WIDTH >= ZONE_NUM.

Ports:
- `clk`  in  1  single clock; FIFO read clock and driver clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `frame_start`  in  1  one-cycle request to transfer one frame.
- `fifo_rd_en`  out  1  FIFO read strobe.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO read data; valid the cycle after `fifo_rd_en`.
- `fifo_rd_empty`  in  1  FIFO empty flag.
- `zone_valid`  out  1  output byte valid.
- `zone_ready`  in  1  downstream accept.
- `zone_data`  out  DATA_WIDTH  brightness byte.
- `zone_idx`  out  IDX_WIDTH  zone index, 0..ZONE_NUM-1.
- `zone_last`  out  1  high with `zone_valid` when `zone_idx` == ZONE_NUM-1.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse when a frame finishes.
- `frame_overrun`  out  1  one-cycle pulse when `frame_start` arrives while busy.

## Operation
- States:
  - IDLE: `frame_start` moves the block to READ and clears `rd_cnt` and `out_cnt`.
  - READ: issues reads until `rd_cnt` == ZONE_NUM, then moves to DRAIN.
  - DRAIN: waits for the final handshake, then moves to DONE.
  - DONE: lasts one cycle, pulses `frame_done`, and returns to IDLE.
- `busy` = (state != IDLE).
- Read issue is combinational.
  - `fifo_rd_en` = READ && !`fifo_rd_empty` && `rd_cnt` < ZONE_NUM && (`buf_cnt` + `inflight` − `pop`) < 2.
  - `pop` = `zone_valid` && `zone_ready`.
  - `inflight` is `fifo_rd_en` delayed one cycle.
- Capture: when `inflight` = 1, `fifo_rd_data` is written into the 2-entry buffer in that cycle. Because of the credit rule the buffer never overflows, and a byte is never dropped.
- Output:
  - `zone_valid` = (`buf_cnt` != 0).
  - `zone_data` = buffer head.
  - `zone_idx` = `out_cnt`.
  - `out_cnt` increments on `pop`.
  - The transition DRAIN→DONE happens on the pop with `zone_last` = 1.
- Width rules: `rd_cnt`, `out_cnt` and `buf_cnt` never wrap; counters are IDX_WIDTH+1 bits.
- Boundary behaviour:
  - FIFO empty mid-frame: `fifo_rd_en` stays low and the state is held. There is no timeout.
  - `frame_start` in any state other than IDLE: ignored, and `frame_overrun` pulses.
  - `frame_start` in the DONE cycle: also treated as an overrun.
  - `zone_ready` low: the buffer fills to 2 and reads stop. `zone_data` and `zone_idx` stay stable while `zone_valid` is high and not accepted.
  - Reset mid-frame clears all state. The FIFO is not touched; its residual bytes are the upstream's responsibility.
- Reset values: all outputs are 0, the state is IDLE, and the buffer is empty.

## Timing
- Let `frame_start` be high in cycle 0 from IDLE, with the FIFO non-empty and `zone_ready` = 1.
  - `busy` = 1 from cycle 1.
  - `fifo_rd_en` = 1 in cycles 1..ZONE_NUM.
  - `zone_valid` = 1 in cycles 3..ZONE_NUM+2 with `zone_idx` 0..ZONE_NUM-1.
  - `frame_done` pulses in cycle ZONE_NUM+3; `busy` is low from cycle ZONE_NUM+4.
- Throughput is 1 byte/cycle when the FIFO is non-empty and `zone_ready` = 1.
- Latency from `fifo_rd_en` to `zone_valid` for that byte is 2 cycles when the buffer is empty.
- `frame_done` and `frame_overrun` are registered pulses, exactly 1 cycle wide.

## Test plan
- ZONE_NUM = 64, FIFO preloaded with 0xFF down to 0xC0, `zone_ready` = 1, `frame_start` pulse:
  - bytes 0xFF..0xC0 appear at idx 0..63 on cycles 3..66;
  - `zone_last` is high only at idx 63;
  - `frame_done` pulses at cycle 67.
- Same stimulus with `zone_ready` toggling 1,0,0,1 repeatedly:
  - the byte sequence is unchanged, with no loss or duplication;
  - data and idx are held while unaccepted;
  - `fifo_rd_en` never fires with `buf_cnt` + `inflight` = 2 and no pop.
- FIFO holds 10 bytes when `frame_start` arrives; the remaining 54 bytes are written 100 cycles later:
  - reads stall at `rd_cnt` = 10 while `fifo_rd_empty` = 1;
  - the frame then completes with idx contiguous and `frame_done` pulsed once.
- Second `frame_start` at cycle 20 of a frame, and another in the DONE cycle:
  - `frame_overrun` pulses once for each;
  - the active frame is unaffected and no new frame starts.
- `rst_n` asserted at cycle 30 of a frame:
  - all outputs go to 0 immediately, the state is IDLE, and the buffer is empty;
  - after release, a new `frame_start` begins at idx 0.
- ZONE_NUM = 1, single byte 0x5A:
  - `zone_valid` is at cycle 3 with idx 0 and `zone_last` = 1;
  - `frame_done` pulses at cycle 4.

Source files
------------

// File: rtl/led_zone_rd_ctrl.sv
// Pulls ZONE_NUM brightness bytes from the zone FIFO per frame_start and streams them out indexed.
// Latency: 2 cycles from fifo_rd_en to zone_valid with an empty buffer; 1 byte/cycle sustained.
// Backpressure: zone_ready low fills the 2-entry skid buffer, then reads stop; an empty FIFO stalls reads.
module led_zone_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ZONE_NUM   = 64,
    parameter int IDX_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  zone_valid,
    input  logic                  zone_ready,
    output logic [DATA_WIDTH-1:0] zone_data,
    output logic [IDX_WIDTH-1:0]  zone_idx,
    output logic                  zone_last,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_overrun
);

    localparam logic [IDX_WIDTH:0] ZONE_NUM_C  = (IDX_WIDTH+1)'(ZONE_NUM);
    localparam logic [IDX_WIDTH:0] ZONE_LAST_C = (IDX_WIDTH+1)'(ZONE_NUM - 1);
    localparam logic [IDX_WIDTH:0] CNT_ONE_C   = (IDX_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_WIDTH:0]    rd_cnt_q, rd_cnt_d;
    logic [IDX_WIDTH:0]    out_cnt_q, out_cnt_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf_mem_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic                  frame_done_q, frame_overrun_q;
    logic                  pop;
    logic [2:0]            credit_used;

    assign zone_valid    = (buf_cnt_q != 2'd0);
    assign pop           = zone_valid && zone_ready;
    assign zone_data     = buf_mem_q[rd_ptr_q];
    assign zone_idx      = out_cnt_q[IDX_WIDTH-1:0];
    assign zone_last     = zone_valid && (out_cnt_q == ZONE_LAST_C);
    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = frame_done_q;
    assign frame_overrun = frame_overrun_q;

    // Buffered plus in-flight bytes, net of this cycle's pop, must leave room for one more.
    assign credit_used = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(pop);
    assign fifo_rd_en  = (state_q == ST_READ) && !fifo_rd_empty &&
                         (rd_cnt_q < ZONE_NUM_C) && (credit_used < 3'd2);

    assign buf_cnt_d = buf_cnt_q + 2'(inflight_q) - 2'(pop);

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        out_cnt_d = out_cnt_q;
        if (fifo_rd_en) begin
            rd_cnt_d = rd_cnt_q + CNT_ONE_C;
        end
        if (pop) begin
            out_cnt_d = out_cnt_q + CNT_ONE_C;
        end
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d   = ST_READ;
                    rd_cnt_d  = '0;
                    out_cnt_d = '0;
                end
            end
            ST_READ: begin
                if (rd_cnt_q == ZONE_NUM_C) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && zone_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            rd_cnt_q        <= '0;
            out_cnt_q       <= '0;
            buf_cnt_q       <= '0;
            inflight_q      <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            buf_mem_q[0]    <= '0;
            buf_mem_q[1]    <= '0;
            frame_done_q    <= 1'b0;
            frame_overrun_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_cnt_q        <= rd_cnt_d;
            out_cnt_q       <= out_cnt_d;
            buf_cnt_q       <= buf_cnt_d;
            inflight_q      <= fifo_rd_en;
            frame_done_q    <= (state_d == ST_DONE);
            frame_overrun_q <= frame_start && (state_q != ST_IDLE);
            // FIFO data lands one cycle after the strobe; capture it into the tail slot.
            if (inflight_q) begin
                buf_mem_q[wr_ptr_q] <= fifo_rd_data;
                wr_ptr_q            <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
        end
    end

endmodule
